pce_bk_ctrl: RTL and testbench

Backup-RAM save/load sequencer for the TGFX16 core. It moves the 8 KB HuC backup RAM between the dual-port BRAM and a mounted save image, one 512-byte sector at a time, using the hps_io sd_* handshake. It also runs the "Format Save" header write and gates save/load availability (bk_ena). It sits between hps_io and the B-port of the backup RAM, and drives the core-reset contribution used while a load is in progress.

---
 rtl/pce_bk_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_pce_bk_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pce_bk_ctrl.sv
// pce_bk_ctrl
// Backup-RAM save/load sequencer. Moves the HuC backup RAM between the BRAM
// B-port and the mounted save image one sector at a time over the hps_io
// sd_* handshake. It also writes the "Format Save" header and gates save/load
// availability.
//
// Ports
//   clk_sys, reset_n          : system clock, asynchronous active-low reset
//   downloading               : ROM download in progress
//   img_mounted/size_nz/ro    : save image mount pulse and qualifiers
//   bk_load, bk_save, format  : request levels, acted on at their rising edge
//   slot                      : save slot, latched when a transfer starts
//   sd_ack                    : hps_io acknowledge
//   sd_lba, sd_rd, sd_wr      : sector address and read/write request
//   sec_idx                   : current sector, high bits of the BRAM B address
//   def_we/def_addr/def_data  : header word write port
//   bk_ena, bk_busy           : save/load permitted, operation in progress
//   bk_loading                : load in progress (held in core reset)
//   bk_err                    : sticky acknowledge timeout
module pce_bk_ctrl #(
  parameter int unsigned SECTORS     = 32'd16,
  parameter int unsigned SLOT_W      = 32'd2,
  parameter int unsigned ACK_TIMEOUT = 32'd16777216
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       downloading,
  input  logic                       img_mounted,
  input  logic                       img_size_nz,
  input  logic                       img_readonly,
  input  logic                       bk_load,
  input  logic                       bk_save,
  input  logic                       format,
  input  logic [SLOT_W-1:0]          slot,
  input  logic                       sd_ack,
  output logic [31:0]                sd_lba,
  output logic                       sd_rd,
  output logic                       sd_wr,
  output logic [$clog2(SECTORS)-1:0] sec_idx,
  output logic                       def_we,
  output logic [1:0]                 def_addr,
  output logic [15:0]                def_data,
  output logic                       bk_ena,
  output logic                       bk_busy,
  output logic                       bk_loading,
  output logic                       bk_err
);

  localparam int unsigned SEC_W = $clog2(SECTORS);
  localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 32'd1);
  localparam int unsigned PAD_W = 32'd32 - SLOT_W - SEC_W;

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECTORS - 32'd1);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(32'd1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 32'd1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_FMT  = 2'd3
  } state_t;

  // Empty-save header, one 16-bit word per address.
  function automatic logic [15:0] hdr_word(input logic [1:0] a);
    logic [15:0] w;
    case (a)
      2'd0:    w = 16'h5548;
      2'd1:    w = 16'h4D42;
      2'd2:    w = 16'h8800;
      2'd3:    w = 16'h8010;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  state_t             state_r, state_nx_s;
  logic               load_q_r, save_q_r, fmt_q_r, ack_q_r, dl_q_r;
  logic [SLOT_W-1:0]  slot_r, slot_nx_s;
  logic               dir_load_r, dir_nx_s;
  logic [SEC_W-1:0]   sec_idx_r, sec_nx_s;
  logic [31:0]        sd_lba_r, lba_nx_s;
  logic               sd_rd_r, rd_nx_s, sd_wr_r, wr_nx_s;
  logic [TO_W-1:0]    to_cnt_r, to_nx_s;
  logic               bk_busy_r, busy_nx_s, bk_loading_r, loading_nx_s;
  logic               bk_err_r, err_nx_s, bk_ena_r;
  logic               def_we_r, we_nx_s;
  logic [1:0]         def_addr_r, addr_nx_s;
  logic [15:0]        def_data_r, data_nx_s;

  logic load_edge_s, save_edge_s, fmt_edge_s, ack_rise_s, ack_fall_s;

  assign load_edge_s = bk_load & ~load_q_r;
  assign save_edge_s = bk_save & ~save_q_r;
  assign fmt_edge_s  = format & ~fmt_q_r;
  assign ack_rise_s  = sd_ack & ~ack_q_r;
  assign ack_fall_s  = ~sd_ack & ack_q_r;

  // Registered copies of the request levels, sd_ack and downloading for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      load_q_r <= 1'b0;
      save_q_r <= 1'b0;
      fmt_q_r  <= 1'b0;
      ack_q_r  <= 1'b0;
      dl_q_r   <= 1'b0;
    end else begin
      load_q_r <= bk_load;
      save_q_r <= bk_save;
      fmt_q_r  <= format;
      ack_q_r  <= sd_ack;
      dl_q_r   <= downloading;
    end
  end

  // Save/load enable: a valid mount during download sets it (and beats a
  // same-cycle clear); a new download start clears it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bk_ena_r <= 1'b0;
    end else if (downloading & img_mounted & img_size_nz & ~img_readonly) begin
      bk_ena_r <= 1'b1;
    end else if (downloading & ~dl_q_r) begin
      bk_ena_r <= 1'b0;
    end else begin
      bk_ena_r <= bk_ena_r;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nx_s   = state_r;
    slot_nx_s    = slot_r;
    dir_nx_s     = dir_load_r;
    sec_nx_s     = sec_idx_r;
    lba_nx_s     = sd_lba_r;
    rd_nx_s      = sd_rd_r;
    wr_nx_s      = sd_wr_r;
    to_nx_s      = to_cnt_r;
    busy_nx_s    = bk_busy_r;
    loading_nx_s = bk_loading_r;
    err_nx_s     = bk_err_r;
    we_nx_s      = 1'b0;
    addr_nx_s    = def_addr_r;
    data_nx_s    = def_data_r;
    case (state_r)
      ST_IDLE: begin
        // An accepted load/save swallows a coincident format edge.
        if ((load_edge_s | save_edge_s) & bk_ena_r) begin
          state_nx_s   = ST_REQ;
          slot_nx_s    = slot;
          dir_nx_s     = load_edge_s;
          sec_nx_s     = {SEC_W{1'b0}};
          lba_nx_s     = {{PAD_W{1'b0}}, slot, {SEC_W{1'b0}}};
          rd_nx_s      = load_edge_s;
          wr_nx_s      = ~load_edge_s;
          to_nx_s      = {TO_W{1'b0}};
          busy_nx_s    = 1'b1;
          loading_nx_s = load_edge_s;
          err_nx_s     = 1'b0;
        end else if (fmt_edge_s) begin
          state_nx_s = ST_FMT;
          we_nx_s    = 1'b1;
          addr_nx_s  = 2'd0;
          data_nx_s  = hdr_word(2'd0);
          busy_nx_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An acknowledge arriving on the final count still wins over the timeout.
        if (ack_rise_s) begin
          rd_nx_s    = 1'b0;
          wr_nx_s    = 1'b0;
          state_nx_s = ST_XFER;
        end else if (to_cnt_r == TO_LAST) begin
          rd_nx_s      = 1'b0;
          wr_nx_s      = 1'b0;
          loading_nx_s = 1'b0;
          busy_nx_s    = 1'b0;
          err_nx_s     = 1'b1;
          state_nx_s   = ST_IDLE;
        end else begin
          to_nx_s = to_cnt_r + TO_ONE;
        end
      end
      ST_XFER: begin
        if (ack_fall_s) begin
          if (sec_idx_r == SEC_LAST) begin
            busy_nx_s    = 1'b0;
            loading_nx_s = 1'b0;
            state_nx_s   = ST_IDLE;
          end else begin
            sec_nx_s   = sec_idx_r + SEC_ONE;
            lba_nx_s   = {{PAD_W{1'b0}}, slot_r, sec_nx_s};
            rd_nx_s    = dir_load_r;
            wr_nx_s    = ~dir_load_r;
            to_nx_s    = {TO_W{1'b0}};
            state_nx_s = ST_REQ;
          end
        end else begin
          state_nx_s = ST_XFER;
        end
      end
      ST_FMT: begin
        // def_addr doubles as the header word counter.
        if (def_addr_r == 2'd3) begin
          busy_nx_s  = 1'b0;
          addr_nx_s  = 2'd0;
          data_nx_s  = 16'h0000;
          state_nx_s = ST_IDLE;
        end else begin
          we_nx_s   = 1'b1;
          addr_nx_s = def_addr_r + 2'd1;
          data_nx_s = hdr_word(addr_nx_s);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      slot_r       <= {SLOT_W{1'b0}};
      dir_load_r   <= 1'b0;
      sec_idx_r    <= {SEC_W{1'b0}};
      sd_lba_r     <= 32'd0;
      sd_rd_r      <= 1'b0;
      sd_wr_r      <= 1'b0;
      to_cnt_r     <= {TO_W{1'b0}};
      bk_busy_r    <= 1'b0;
      bk_loading_r <= 1'b0;
      bk_err_r     <= 1'b0;
      def_we_r     <= 1'b0;
      def_addr_r   <= 2'd0;
      def_data_r   <= 16'h0000;
    end else begin
      slot_r       <= slot_nx_s;
      dir_load_r   <= dir_nx_s;
      sec_idx_r    <= sec_nx_s;
      sd_lba_r     <= lba_nx_s;
      sd_rd_r      <= rd_nx_s;
      sd_wr_r      <= wr_nx_s;
      to_cnt_r     <= to_nx_s;
      bk_busy_r    <= busy_nx_s;
      bk_loading_r <= loading_nx_s;
      bk_err_r     <= err_nx_s;
      def_we_r     <= we_nx_s;
      def_addr_r   <= addr_nx_s;
      def_data_r   <= data_nx_s;
    end
  end

  assign sd_lba     = sd_lba_r;
  assign sd_rd      = sd_rd_r;
  assign sd_wr      = sd_wr_r;
  assign sec_idx    = sec_idx_r;
  assign def_we     = def_we_r;
  assign def_addr   = def_addr_r;
  assign def_data   = def_data_r;
  assign bk_ena     = bk_ena_r;
  assign bk_busy    = bk_busy_r;
  assign bk_loading = bk_loading_r;
  assign bk_err     = bk_err_r;

endmodule

// File: tb/tb_pce_bk_ctrl.sv
// Scoreboard bench for pce_bk_ctrl: stimulus pushes expected sector requests
// and header writes into queues, a monitor pops and compares them whenever the
// DUT raises a request or a header strobe, and a responder answers sd_rd/sd_wr
// with randomly timed sd_ack pulses.
module tb_pce_bk_ctrl;

  localparam int SECTORS = 16;
  localparam int TO      = 16;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] lba;
    logic [3:0]  sec;
  } req_t;

  typedef struct packed {
    logic [1:0]  addr;
    logic [15:0] data;
  } fmt_t;

  logic        clk_sys = 1'b0;
  logic        reset_n, downloading, img_mounted, img_size_nz, img_readonly;
  logic        bk_load, bk_save, format, sd_ack;
  logic [1:0]  slot;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, def_we, bk_ena, bk_busy, bk_loading, bk_err;
  logic [3:0]  sec_idx;
  logic [1:0]  def_addr;
  logic [15:0] def_data;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   wr_hi_cnt = 0;
  logic ack_en;
  req_t exp_req_q[$];
  fmt_t exp_fmt_q[$];
  logic [15:0] hdr [4];

  pce_bk_ctrl #(.SECTORS(SECTORS), .SLOT_W(2), .ACK_TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .downloading(downloading),
    .img_mounted(img_mounted), .img_size_nz(img_size_nz), .img_readonly(img_readonly),
    .bk_load(bk_load), .bk_save(bk_save), .format(format), .slot(slot),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sec_idx(sec_idx), .def_we(def_we), .def_addr(def_addr), .def_data(def_data),
    .bk_ena(bk_ena), .bk_busy(bk_busy), .bk_loading(bk_loading), .bk_err(bk_err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Monitor: pops expectations on every new sector request and header strobe.
  initial begin
    logic req_prev;
    req_t e;
    fmt_t f;
    req_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (sd_wr) wr_hi_cnt++;
      if ((sd_rd | sd_wr) && !req_prev) begin
        if (exp_req_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexp_req: got rd=%0b wr=%0b lba=%0d, expected no request", sd_rd, sd_wr, sd_lba);
        end else begin
          e = exp_req_q.pop_front();
          chk1("req_rd", sd_rd, e.is_rd);
          chk1("req_wr", sd_wr, ~e.is_rd);
          chk("req_lba", sd_lba, e.lba);
          chk("req_sec", {28'd0, sec_idx}, {28'd0, e.sec});
          chk1("req_loading", bk_loading, e.is_rd);
          chk1("req_busy", bk_busy, 1'b1);
        end
      end
      req_prev = sd_rd | sd_wr;
      if (def_we) begin
        if (exp_fmt_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexp_def_we: got addr=%0d data=%0h, expected no write", def_addr, def_data);
        end else begin
          f = exp_fmt_q.pop_front();
          chk("def_addr", {30'd0, def_addr}, {30'd0, f.addr});
          chk("def_data", {16'd0, def_data}, {16'd0, f.data});
          chk1("def_busy", bk_busy, 1'b1);
        end
      end
    end
  end

  // Responder: random delay before sd_ack rises, random hold before it falls.
  initial begin
    int rs_state;
    int rs_cnt;
    rs_state = 0;
    rs_cnt = 0;
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n || !ack_en) begin
        sd_ack = 1'b0;
        rs_state = 0;
      end else begin
        case (rs_state)
          0: if (sd_rd || sd_wr) begin rs_cnt = int'($urandom_range(0, 3)); rs_state = 1; end
          1: if (rs_cnt == 0) begin sd_ack = 1'b1; rs_state = 2; end else rs_cnt--;
          2: begin
            chk1("req_drop", sd_rd | sd_wr, 1'b0);
            rs_cnt = int'($urandom_range(0, 2));
            rs_state = 3;
          end
          3: if (rs_cnt == 0) begin sd_ack = 1'b0; last_fall_cyc = cyc; rs_state = 0; end else rs_cnt--;
          default: rs_state = 0;
        endcase
      end
    end
  end

  // Issue a load/save edge and queue the expected sector requests.
  task automatic do_xfer(input logic ld, input logic sv, input logic [1:0] sl,
                         input int nsec, input logic hold);
    req_t e;
    for (int i = 0; i < nsec; i++) begin
      e.is_rd = ld;
      e.lba   = 32'(sl) * 32'(SECTORS) + 32'(i);
      e.sec   = 4'(i);
      exp_req_q.push_back(e);
    end
    @(posedge clk_sys); #1;
    slot = sl; bk_load = ld; bk_save = sv;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk1("req_start", sd_rd | sd_wr, 1'b1);
    chk1("busy_start", bk_busy, 1'b1);
    chk1("err_clear", bk_err, 1'b0);
    chk1("loading_start", bk_loading, ld);
    @(posedge clk_sys); #1;
    slot = 2'($urandom_range(0, 3));
    if (!hold) begin bk_load = 1'b0; bk_save = 1'b0; end
  endtask

  task automatic wait_idle(input int budget, output int fall_cyc);
    int n;
    n = 0;
    while (bk_busy !== 1'b0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk1("busy_done", bk_busy, 1'b0);
    fall_cyc = cyc;
  endtask

  task automatic finish_xfer();
    int fc;
    wait_idle(2000, fc);
    chk("busy_fall_cyc", fc, last_fall_cyc + 1);
    chk("req_q_empty", exp_req_q.size(), 32'd0);
    chk1("loading_end", bk_loading, 1'b0);
    chk1("err_end", bk_err, 1'b0);
    chk1("rd_end", sd_rd, 1'b0);
    chk1("wr_end", sd_wr, 1'b0);
  endtask

  task automatic mount(input logic ro);
    @(posedge clk_sys); #1;
    img_mounted = 1'b1; img_size_nz = 1'b1; img_readonly = ro;
    @(posedge clk_sys); #1;
    img_mounted = 1'b0; img_readonly = 1'b0;
  endtask

  initial begin
    fmt_t f;
    int   fc;
    int   n;
    int   wr_base;
    hdr[0] = 16'h5548; hdr[1] = 16'h4D42; hdr[2] = 16'h8800; hdr[3] = 16'h8010;
    reset_n = 1'b0; downloading = 1'b0; img_mounted = 1'b0; img_size_nz = 1'b0;
    img_readonly = 1'b0; bk_load = 1'b0; bk_save = 1'b0; format = 1'b0;
    slot = 2'd0; ack_en = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk1("rst_rd", sd_rd, 1'b0);
    chk1("rst_wr", sd_wr, 1'b0);
    chk("rst_lba", sd_lba, 32'd0);
    chk1("rst_def_we", def_we, 1'b0);
    chk("rst_def", {14'd0, def_addr, def_data}, 32'd0);
    chk1("rst_ena", bk_ena, 1'b0);
    chk1("rst_busy", bk_busy, 1'b0);
    chk1("rst_loading", bk_loading, 1'b0);
    chk1("rst_err", bk_err, 1'b0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;

    // bk_ena gating
    downloading = 1'b1;
    repeat (2) @(posedge clk_sys);
    mount(1'b0);
    @(negedge clk_sys); chk1("ena_mount", bk_ena, 1'b1);
    @(posedge clk_sys); #1; downloading = 1'b0;
    @(posedge clk_sys); #1; downloading = 1'b1;
    @(posedge clk_sys); #1;
    @(negedge clk_sys); chk1("ena_dl_clear", bk_ena, 1'b0);
    mount(1'b1);
    @(negedge clk_sys); chk1("ena_readonly", bk_ena, 1'b0);
    @(posedge clk_sys); #1; downloading = 1'b0;
    @(posedge clk_sys); #1;
    downloading = 1'b1; img_mounted = 1'b1; img_size_nz = 1'b1;
    @(posedge clk_sys); #1; img_mounted = 1'b0; downloading = 1'b0;
    @(negedge clk_sys); chk1("ena_set_wins", bk_ena, 1'b1);

    // Save slot 2, then coincident load+save on slot 1
    do_xfer(1'b0, 1'b1, 2'd2, SECTORS, 1'b0);
    finish_xfer();
    do_xfer(1'b1, 1'b1, 2'd1, SECTORS, 1'b0);
    finish_xfer();

    // Randomized transfers
    for (int k = 0; k < 4; k++) begin
      int op;
      op = int'($urandom_range(0, 2));
      repeat (int'($urandom_range(1, 4))) @(posedge clk_sys);
      do_xfer(op != 0, op != 1, 2'($urandom_range(0, 3)), SECTORS, 1'b0);
      finish_xfer();
    end

    // Acknowledge timeout, then recovery
    @(posedge clk_sys); #1; ack_en = 1'b0;
    wr_base = wr_hi_cnt;
    do_xfer(1'b0, 1'b1, 2'd3, 1, 1'b0);
    wait_idle(200, fc);
    chk("to_wr_cycles", wr_hi_cnt - wr_base, TO);
    chk1("to_err", bk_err, 1'b1);
    chk1("to_wr_low", sd_wr, 1'b0);
    repeat (3) @(negedge clk_sys);
    chk1("to_err_sticky", bk_err, 1'b1);
    @(posedge clk_sys); #1; ack_en = 1'b1;
    do_xfer(1'b0, 1'b1, 2'd3, SECTORS, 1'b0);
    finish_xfer();

    // Format in IDLE
    for (int a = 0; a < 4; a++) begin
      f.addr = 2'(a);
      f.data = hdr[a];
      exp_fmt_q.push_back(f);
    end
    @(posedge clk_sys); #1; format = 1'b1;
    @(negedge clk_sys); chk1("fmt_early", def_we, 1'b0);
    @(negedge clk_sys); chk1("fmt_start", def_we, 1'b1);
    repeat (6) @(negedge clk_sys);
    chk("fmt_q_empty", exp_fmt_q.size(), 32'd0);
    chk1("fmt_busy_end", bk_busy, 1'b0);
    @(posedge clk_sys); #1; format = 1'b0;

    // Format edge during a transfer is ignored
    do_xfer(1'b0, 1'b1, 2'd0, SECTORS, 1'b0);
    format = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1; format = 1'b0;
    finish_xfer();

    // Asynchronous reset during sector 5 of a load, bk_load held high
    do_xfer(1'b1, 1'b0, 2'd1, SECTORS, 1'b1);
    n = 0;
    while (exp_req_q.size() > 10 && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    chk("sector5_reached", exp_req_q.size(), 32'd10);
    @(posedge clk_sys); #3;
    reset_n = 1'b0;
    #1;
    chk1("arst_rd", sd_rd, 1'b0);
    chk1("arst_loading", bk_loading, 1'b0);
    chk1("arst_busy", bk_busy, 1'b0);
    chk("arst_lba", sd_lba, 32'd0);
    exp_req_q.delete();
    @(posedge clk_sys); #1; reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    chk1("post_rst_busy", bk_busy, 1'b0);
    chk1("post_rst_ena", bk_ena, 1'b0);
    chk1("post_rst_rd", sd_rd, 1'b0);
    bk_load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
